// File: rtl/cdb_result_arbiter_pkg.sv
// Shared sizes, state encodings and the round-robin scan used by the CDB
// result arbiter (and reusable by the issue-side FU selector).
package cdb_result_arbiter_pkg;

  localparam int FU_NUM    = 4;
  localparam int WORD_SIZE = 32;
  localparam int RB_INDEX  = 4;
  localparam int FU_IDX_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  localparam logic [RB_INDEX-1:0] NULL = '1;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

  typedef enum logic {
    OUT_IDLE,
    OUT_HOLD
  } out_state_t;

  typedef struct packed {
    logic                found;
    logic [FU_IDX_W-1:0] idx;
  } pick_t;

  function automatic logic [FU_NUM-1:0] onehot(input logic [FU_IDX_W-1:0] idx);
    logic [FU_NUM-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Scan from ptr upward with wrap; walking offsets high-to-low lets the
  // closest requester to ptr overwrite any farther one.
  function automatic pick_t rr_pick(input logic [FU_NUM-1:0]   req,
                                    input logic [FU_IDX_W-1:0] ptr);
    pick_t r;
    int    k;
    r.found = 1'b0;
    r.idx   = '0;
    for (int off = FU_NUM - 1; off >= 0; off--) begin
      k = int'(ptr) + off;
      if (k >= FU_NUM) k = k - FU_NUM;
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = FU_IDX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdb_result_arbiter_if.sv
// Bus bundle between the functional units, the arbiter and the reorder buffer.
interface cdb_result_arbiter_if;
  import cdb_result_arbiter_pkg::*;

  logic [FU_NUM-1:0]           fu_valid;
  logic [FU_NUM*WORD_SIZE-1:0] fu_data;
  logic [FU_NUM*RB_INDEX-1:0]  fu_dest;
  logic [FU_NUM-1:0]           fu_ack;
  logic                        wb_valid;
  logic [WORD_SIZE-1:0]        wb_data;
  logic [RB_INDEX-1:0]         wb_dest;
  logic [FU_NUM-1:0]           wb_fu;
  logic                        wb_ready;
  logic                        flush;
  logic [FU_NUM-1:0]           pending;

  // master is the arbiter, slave is the FU/ROB side driving it
  modport master (
    input  fu_valid, fu_data, fu_dest, wb_ready, flush,
    output fu_ack, wb_valid, wb_data, wb_dest, wb_fu, pending
  );

  modport slave (
    output fu_valid, fu_data, fu_dest, wb_ready, flush,
    input  fu_ack, wb_valid, wb_data, wb_dest, wb_fu, pending
  );

endinterface

// File: rtl/cdb_result_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: request mask + pointer -> winner index.
module cdb_result_arbiter_rr_priority_pick
  import cdb_result_arbiter_pkg::*;
(
  input  logic [FU_NUM-1:0]   req,
  input  logic [FU_IDX_W-1:0] rr_ptr,
  output logic [FU_IDX_W-1:0] winner,
  output logic                found
);

  pick_t pick;

  always_comb begin
    pick = rr_pick(req, rr_ptr);
  end

  assign winner = pick.idx;
  assign found  = pick.found;

endmodule

// File: rtl/cdb_result_arbiter.sv
// Captures FU results into one-entry slots and drains them round-robin onto
// the single registered reorder-buffer write-back channel.
module cdb_result_arbiter
  import cdb_result_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  cdb_result_arbiter_if.master bus
);

  slot_state_t          slot_q      [FU_NUM];
  slot_state_t          slot_d      [FU_NUM];
  logic [WORD_SIZE-1:0] slot_data_q [FU_NUM];
  logic [WORD_SIZE-1:0] slot_data_d [FU_NUM];
  logic [RB_INDEX-1:0]  slot_dest_q [FU_NUM];
  logic [RB_INDEX-1:0]  slot_dest_d [FU_NUM];

  out_state_t           out_q, out_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic [RB_INDEX-1:0]  wb_dest_q, wb_dest_d;
  logic [FU_NUM-1:0]    wb_fu_q, wb_fu_d;
  logic [FU_NUM-1:0]    fu_ack_q, fu_ack_d;
  logic [FU_IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [FU_NUM-1:0]    full_mask;
  logic [FU_IDX_W-1:0]  win_idx;
  logic                 win_found;
  logic                 load;

  always_comb begin
    full_mask = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      full_mask[i] = (slot_q[i] == SLOT_FULL);
    end
  end

  cdb_result_arbiter_rr_priority_pick u_pick (
    .req    (full_mask),
    .rr_ptr (rr_ptr_q),
    .winner (win_idx),
    .found  (win_found)
  );

  assign load = (out_q == OUT_IDLE) || bus.wb_ready;

  // Grant and capture both look only at registered slot state, so a slot
  // emptied by a grant cannot be refilled until the following edge.
  always_comb begin
    for (int i = 0; i < FU_NUM; i++) begin
      slot_d[i]      = slot_q[i];
      slot_data_d[i] = slot_data_q[i];
      slot_dest_d[i] = slot_dest_q[i];
    end
    out_d     = out_q;
    wb_data_d = wb_data_q;
    wb_dest_d = wb_dest_q;
    wb_fu_d   = wb_fu_q;
    rr_ptr_d  = rr_ptr_q;
    fu_ack_d  = '0;

    if (bus.flush) begin
      for (int i = 0; i < FU_NUM; i++) begin
        slot_d[i] = SLOT_EMPTY;
      end
      out_d     = OUT_IDLE;
      wb_dest_d = NULL;
      wb_fu_d   = '0;
    end else begin
      if (load) begin
        if (win_found) begin
          out_d           = OUT_HOLD;
          wb_data_d       = slot_data_q[win_idx];
          wb_dest_d       = slot_dest_q[win_idx];
          wb_fu_d         = onehot(win_idx);
          slot_d[win_idx] = SLOT_EMPTY;
          rr_ptr_d        = (win_idx == FU_IDX_W'(FU_NUM - 1)) ? '0 : win_idx + 1'b1;
        end else begin
          out_d     = OUT_IDLE;
          wb_dest_d = NULL;
          wb_fu_d   = '0;
        end
      end
      for (int i = 0; i < FU_NUM; i++) begin
        if (slot_q[i] == SLOT_EMPTY && bus.fu_valid[i]) begin
          slot_d[i]      = SLOT_FULL;
          slot_data_d[i] = bus.fu_data[i*WORD_SIZE +: WORD_SIZE];
          slot_dest_d[i] = bus.fu_dest[i*RB_INDEX +: RB_INDEX];
          fu_ack_d[i]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FU_NUM; i++) begin
        slot_q[i]      <= SLOT_EMPTY;
        slot_data_q[i] <= '0;
        slot_dest_q[i] <= NULL;
      end
      out_q     <= OUT_IDLE;
      wb_data_q <= '0;
      wb_dest_q <= NULL;
      wb_fu_q   <= '0;
      fu_ack_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        slot_q[i]      <= slot_d[i];
        slot_data_q[i] <= slot_data_d[i];
        slot_dest_q[i] <= slot_dest_d[i];
      end
      out_q     <= out_d;
      wb_data_q <= wb_data_d;
      wb_dest_q <= wb_dest_d;
      wb_fu_q   <= wb_fu_d;
      fu_ack_q  <= fu_ack_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.fu_ack   = fu_ack_q;
  assign bus.wb_valid = (out_q == OUT_HOLD);
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_dest  = wb_dest_q;
  assign bus.wb_fu    = wb_fu_q;
  assign bus.pending  = full_mask;

endmodule

// File: tb/tb_cdb_result_arbiter.sv
// Directed bench for cdb_result_arbiter: capture/ack, round-robin order,
// back-pressure, flush and asynchronous reset.
module tb_cdb_result_arbiter;
  import cdb_result_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cdb_result_arbiter_if bus();

  cdb_result_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [WORD_SIZE-1:0] d,
                        input logic [RB_INDEX-1:0] dst);
    bus.fu_data[i*WORD_SIZE +: WORD_SIZE] = d;
    bus.fu_dest[i*RB_INDEX +: RB_INDEX]   = dst;
  endtask

  task automatic do_reset();
    bus.fu_valid = '0;
    bus.fu_data  = '0;
    bus.fu_dest  = '0;
    bus.wb_ready = 1'b1;
    bus.flush    = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_dest !== 4'hF || bus.wb_fu !== 4'b0000 ||
        bus.wb_data !== 32'h0 || bus.fu_ack !== 4'b0000 || bus.pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_state actual v=%b d=%h fu=%b data=%h ack=%b pend=%b required v=0 d=f fu=0000 data=0 ack=0000 pend=0000",
               bus.wb_valid, bus.wb_dest, bus.wb_fu, bus.wb_data, bus.fu_ack, bus.pending);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_fu(1, 32'h0000_0005, 4'd3);
    bus.fu_valid = 4'b0010;
    tick();
    checks++;
    if (bus.fu_ack !== 4'b0010 || bus.wb_valid !== 1'b0 || bus.pending !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL single_capture actual ack=%b v=%b pend=%b required ack=0010 v=0 pend=0010",
               bus.fu_ack, bus.wb_valid, bus.pending);
    end
    bus.fu_valid = '0;
    tick();
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h5 || bus.wb_dest !== 4'd3 ||
        bus.wb_fu !== 4'b0010 || bus.fu_ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_wb actual v=%b data=%h d=%h fu=%b ack=%b required v=1 data=5 d=3 fu=0010 ack=0000",
               bus.wb_valid, bus.wb_data, bus.wb_dest, bus.wb_fu, bus.fu_ack);
    end
    tick();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_dest !== 4'hF || bus.pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_idle actual v=%b d=%h pend=%b required v=0 d=f pend=0000",
               bus.wb_valid, bus.wb_dest, bus.pending);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < 4; i++) set_fu(i, 32'h10 + i, 4'(8 + i));
    bus.fu_valid = 4'b1111;
    tick();
    checks++;
    if (bus.fu_ack !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL all4_ack actual=%b required=1111", bus.fu_ack);
    end
    bus.fu_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 4'(1 << i) ||
          bus.wb_data !== 32'h10 + i || bus.wb_dest !== 4'(8 + i)) begin
        errors++;
        $display("[TB] FAIL all4_grant%0d actual v=%b fu=%b data=%h d=%h required v=1 fu=%b data=%h d=%h",
                 i, bus.wb_valid, bus.wb_fu, bus.wb_data, bus.wb_dest, 4'(1 << i), 32'h10 + i, 4'(8 + i));
      end
    end
    tick();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_dest !== 4'hF) begin
      errors++;
      $display("[TB] FAIL all4_idle actual v=%b d=%h required v=0 d=f", bus.wb_valid, bus.wb_dest);
    end
    // pointer should be back at 0, so FU0 beats FU3
    set_fu(0, 32'h20, 4'd1);
    set_fu(3, 32'h23, 4'd2);
    bus.fu_valid = 4'b1001;
    tick();
    bus.fu_valid = '0;
    tick();
    checks++;
    if (bus.wb_fu !== 4'b0001 || bus.wb_data !== 32'h20) begin
      errors++;
      $display("[TB] FAIL all4_ptr_wrap_first actual fu=%b data=%h required fu=0001 data=20", bus.wb_fu, bus.wb_data);
    end
    tick();
    checks++;
    if (bus.wb_fu !== 4'b1000 || bus.wb_data !== 32'h23) begin
      errors++;
      $display("[TB] FAIL all4_ptr_wrap_second actual fu=%b data=%h required fu=1000 data=23", bus.wb_fu, bus.wb_data);
    end
  endtask

  task automatic test_fairness();
    logic [3:0]  exp_fu;
    logic [31:0] exp_data;
    do_reset();
    set_fu(0, 32'hA0, 4'd4);
    set_fu(2, 32'hA2, 4'd6);
    bus.fu_valid = 4'b0101;
    tick();
    checks++;
    if (bus.fu_ack !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL fair_ack actual=%b required=0101", bus.fu_ack);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_fu   = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_data = (k % 2 == 0) ? 32'hA0 : 32'hA2;
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_fu !== exp_fu || bus.wb_data !== exp_data) begin
        errors++;
        $display("[TB] FAIL fair_grant%0d actual v=%b fu=%b data=%h required v=1 fu=%b data=%h",
                 k, bus.wb_valid, bus.wb_fu, bus.wb_data, exp_fu, exp_data);
      end
    end
    bus.fu_valid = '0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_fu(3, 32'h33, 4'd5);
    bus.fu_valid = 4'b1000;
    tick();
    bus.fu_valid = '0;
    bus.wb_ready = 1'b0;
    tick();
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 4'b1000 || bus.wb_data !== 32'h33) begin
      errors++;
      $display("[TB] FAIL bp_first actual v=%b fu=%b data=%h required v=1 fu=1000 data=33",
               bus.wb_valid, bus.wb_fu, bus.wb_data);
    end
    set_fu(0, 32'h44, 4'd6);
    bus.fu_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        checks++;
        if (bus.fu_ack !== 4'b0001) begin
          errors++;
          $display("[TB] FAIL bp_fu0_ack actual=%b required=0001", bus.fu_ack);
        end
        bus.fu_valid = '0;
      end
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 4'b1000 || bus.wb_data !== 32'h33 ||
          bus.wb_dest !== 4'd5 || bus.pending !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL bp_stable%0d actual v=%b fu=%b data=%h d=%h pend=%b required v=1 fu=1000 data=33 d=5 pend=0001",
                 k, bus.wb_valid, bus.wb_fu, bus.wb_data, bus.wb_dest, bus.pending);
      end
    end
    bus.wb_ready = 1'b1;
    tick();
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 4'b0001 || bus.wb_data !== 32'h44 || bus.wb_dest !== 4'd6) begin
      errors++;
      $display("[TB] FAIL bp_release actual v=%b fu=%b data=%h d=%h required v=1 fu=0001 data=44 d=6",
               bus.wb_valid, bus.wb_fu, bus.wb_data, bus.wb_dest);
    end
    tick();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_dest !== 4'hF) begin
      errors++;
      $display("[TB] FAIL bp_idle actual v=%b d=%h required v=0 d=f", bus.wb_valid, bus.wb_dest);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) set_fu(i, 32'h40 + i, 4'(i));
    bus.fu_valid = 4'b0111;
    tick();
    bus.fu_valid = '0;
    tick();
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 4'b0001 || bus.pending !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL flush_pre actual v=%b fu=%b pend=%b required v=1 fu=0001 pend=0110",
               bus.wb_valid, bus.wb_fu, bus.pending);
    end
    set_fu(0, 32'h50, 4'd1);
    set_fu(3, 32'h53, 4'd2);
    bus.fu_valid = 4'b1001;
    bus.flush    = 1'b1;
    tick();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_dest !== 4'hF || bus.pending !== 4'b0000 || bus.fu_ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL flush_clear actual v=%b d=%h pend=%b ack=%b required v=0 d=f pend=0000 ack=0000",
               bus.wb_valid, bus.wb_dest, bus.pending, bus.fu_ack);
    end
    bus.flush = 1'b0;
    tick();
    checks++;
    if (bus.fu_ack !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL flush_recapture actual ack=%b required ack=1001", bus.fu_ack);
    end
    bus.fu_valid = '0;
    // pointer kept at 1 across the flush, so FU3 precedes FU0
    tick();
    checks++;
    if (bus.wb_fu !== 4'b1000 || bus.wb_data !== 32'h53) begin
      errors++;
      $display("[TB] FAIL flush_ptr_first actual fu=%b data=%h required fu=1000 data=53", bus.wb_fu, bus.wb_data);
    end
    tick();
    checks++;
    if (bus.wb_fu !== 4'b0001 || bus.wb_data !== 32'h50) begin
      errors++;
      $display("[TB] FAIL flush_ptr_second actual fu=%b data=%h required fu=0001 data=50", bus.wb_fu, bus.wb_data);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_fu(1, 32'h61, 4'd7);
    set_fu(2, 32'h62, 4'd9);
    bus.fu_valid = 4'b0110;
    tick();
    bus.fu_valid = '0;
    tick();
    checks++;
    if (bus.wb_fu !== 4'b0010 || bus.pending !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL areset_pre actual fu=%b pend=%b required fu=0010 pend=0100", bus.wb_fu, bus.pending);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_dest !== 4'hF || bus.wb_fu !== 4'b0000 ||
        bus.wb_data !== 32'h0 || bus.pending !== 4'b0000 || bus.fu_ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL areset_immediate actual v=%b d=%h fu=%b data=%h pend=%b ack=%b required v=0 d=f fu=0000 data=0 pend=0000 ack=0000",
               bus.wb_valid, bus.wb_dest, bus.wb_fu, bus.wb_data, bus.pending, bus.fu_ack);
    end
    #1;
    reset = 1'b0;
    set_fu(0, 32'h70, 4'hA);
    set_fu(2, 32'h72, 4'hB);
    bus.fu_valid = 4'b0101;
    tick();
    bus.fu_valid = '0;
    tick();
    checks++;
    if (bus.wb_fu !== 4'b0001 || bus.wb_data !== 32'h70 || bus.wb_dest !== 4'hA) begin
      errors++;
      $display("[TB] FAIL areset_ptr_first actual fu=%b data=%h d=%h required fu=0001 data=70 d=a",
               bus.wb_fu, bus.wb_data, bus.wb_dest);
    end
    tick();
    checks++;
    if (bus.wb_fu !== 4'b0100 || bus.wb_data !== 32'h72) begin
      errors++;
      $display("[TB] FAIL areset_ptr_second actual fu=%b data=%h required fu=0100 data=72", bus.wb_fu, bus.wb_data);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.fu_valid = '0;
    bus.fu_data  = '0;
    bus.fu_dest  = '0;
    bus.wb_ready = 1'b1;
    bus.flush    = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_back_pressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
